// File: rtl/dram_port_arbiter.sv
// dram_port_arbiter: round-robin owner of a single multi-lane DRAM port, one whole transaction per grant.
// Ports:
//   clk, reset            clock (rising edge), asynchronous active-high reset
//   req_en/rdwr/addr/wdata per-requester transaction request (|req_en[i] = pending)
//   req_valid             per-lane completion strobe, routed to the current winner only
//   req_rdata             DRAM read bytes, broadcast to all requesters
//   req_err               one-cycle watchdog abort pulse to the winner
//   grant                 one-hot port owner
//   dram_*                DRAM-side enables, direction, addresses, write data, read data and valids
module dram_port_arbiter #(
    parameter int NREQ    = 2,
    parameter int LANES   = 8,
    parameter int AW      = 64,
    parameter int TIMEOUT = 1024
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NREQ-1:0][LANES-1:0]         req_en,
    input  logic [NREQ-1:0]                    req_rdwr,
    input  logic [NREQ-1:0][LANES-1:0][AW-1:0] req_addr,
    input  logic [NREQ-1:0][LANES-1:0][7:0]    req_wdata,
    output logic [NREQ-1:0][LANES-1:0]         req_valid,
    output logic [LANES-1:0][7:0]              req_rdata,
    output logic [NREQ-1:0]                    req_err,
    output logic [NREQ-1:0]                    grant,
    output logic [LANES-1:0]                   dram_en,
    output logic                               dram_rdwr,
    output logic [LANES-1:0][AW-1:0]           dram_addr,
    output logic [LANES-1:0][7:0]              dram_data_out,
    input  logic [LANES-1:0][7:0]              dram_data_in,
    input  logic [LANES-1:0]                   dram_valid
);
    localparam int IW = $clog2(NREQ);
    localparam int WW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

    state_t           state;
    logic [IW-1:0]    rr_ptr, win, pick, idx;
    logic             found, busy, all_done, wd_fire;
    logic [LANES-1:0] lat_en, done_mask, hit;
    logic [WW-1:0]    wd_cnt;

    // Scan downwards so the requester closest to rr_ptr is the last (winning) assignment.
    always_comb begin
        pick  = rr_ptr;
        idx   = rr_ptr;
        found = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = IW'((int'(rr_ptr) + k) % NREQ);
            if (|req_en[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    assign busy      = state == BUSY;
    assign hit       = dram_valid & lat_en & ~done_mask;
    assign all_done  = (done_mask | (dram_valid & lat_en)) == lat_en;
    assign wd_fire   = TIMEOUT != 0 && wd_cnt == WD_LAST && !all_done;
    assign dram_en   = busy ? lat_en & ~done_mask : '0;
    assign req_rdata = dram_data_in;

    always_comb begin
        req_valid      = '0;
        req_valid[win] = busy ? hit : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            win           <= '0;
            grant         <= '0;
            lat_en        <= '0;
            done_mask     <= '0;
            wd_cnt        <= '0;
            req_err       <= '0;
            dram_rdwr     <= 1'b0;
            dram_addr     <= '0;
            dram_data_out <= '0;
        end else begin
            req_err <= '0;
            case (state)
                IDLE: if (found) begin
                    win           <= pick;
                    grant         <= NREQ'(1) << pick;
                    lat_en        <= req_en[pick];
                    dram_rdwr     <= req_rdwr[pick];
                    dram_addr     <= req_addr[pick];
                    dram_data_out <= req_wdata[pick];
                    done_mask     <= '0;
                    wd_cnt        <= '0;
                    state         <= BUSY;
                end
                BUSY: begin
                    done_mask <= done_mask | (dram_valid & lat_en);
                    wd_cnt    <= wd_cnt + 1'b1;
                    if (all_done) begin
                        state <= RELEASE;
                    end else if (wd_fire) begin
                        req_err[win] <= 1'b1;
                        state        <= RELEASE;
                    end
                end
                // Grant is held through this cycle so the winner can drop stale enables before re-arbitration.
                RELEASE: begin
                    rr_ptr <= win == IW'(NREQ - 1) ? '0 : win + 1'b1;
                    grant  <= '0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
